// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared pipeline-control definitions for the 5-stage core: sequencing states
// and the architectural register-index width.
package pipe_stall_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

endpackage : pipe_stall_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule : sat_counter

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencing for the F/D/E/M/W registers: load-use, branch redirect
// and data-memory wait handling, with timeout detection and perf counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] rs1D,
  input  logic [REG_IDX_W-1:0] rs2D,
  input  logic [REG_IDX_W-1:0] rdE,
  input  logic                 memreadE,
  input  logic                 pcsrcE,
  input  logic                 memaccessM,
  input  logic                 dmem_ready,
  input  logic                 cnt_clr,
  output logic                 stallF,
  output logic                 stallD,
  output logic                 stallE,
  output logic                 stallM,
  output logic                 flushD,
  output logic                 flushE,
  output logic                 flushW,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       freeze, loaduse, branch_flush;

  assign freeze  = memaccessM & ~dmem_ready;
  assign loaduse = memreadE & (rdE != '0) & ((rdE == rs1D) | (rdE == rs2D));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_nxt    = state;
    stallF       = 1'b0;
    stallD       = 1'b0;
    stallE       = 1'b0;
    stallM       = 1'b0;
    flushD       = 1'b0;
    flushE       = 1'b0;
    flushW       = 1'b0;
    mem_timeout  = 1'b0;
    branch_flush = 1'b0;

    case (state)
      ST_RUN:      if (freeze)  state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!freeze) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase

    // Outputs are combinational, so they are forced low while reset is held.
    if (rst_n) begin
      if (freeze) begin
        stallF      = 1'b1;
        stallD      = 1'b1;
        stallE      = 1'b1;
        stallM      = 1'b1;
        flushW      = 1'b1;
        mem_timeout = (wait_cnt == WAIT_LAST);
      end else if (pcsrcE) begin
        flushD       = 1'b1;
        flushE       = 1'b1;
        branch_flush = 1'b1;
      end else if (loaduse) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

  // Timeout does not release the freeze; it only restarts the wait count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (freeze && (wait_cnt != WAIT_LAST)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= 8'd0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (stallF),
    .q     (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (branch_flush),
    .q     (flush_events)
  );

endmodule : pipe_stall_ctrl

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl built with TIMEOUT=4 and CNT_W=4 so the
// timeout and saturation boundaries are reachable in a few cycles.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;

  // {stallF,stallD,stallE,stallM,flushD,flushE,flushW,mem_timeout}
  localparam logic [7:0] C_IDLE   = 8'b0000_0000;
  localparam logic [7:0] C_LU     = 8'b1100_0100;
  localparam logic [7:0] C_BR     = 8'b0000_1100;
  localparam logic [7:0] C_FRZ    = 8'b1111_0010;
  localparam logic [7:0] C_FRZ_TO = 8'b1111_0011;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1D, rs2D, rdE;
  logic memreadE, pcsrcE, memaccessM, dmem_ready, cnt_clr;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_events;
  logic [7:0] ctrl;

  int vecs = 0;
  int errs = 0;

  assign ctrl = {stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_timeout};

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rs1D         (rs1D),
    .rs2D         (rs2D),
    .rdE          (rdE),
    .memreadE     (memreadE),
    .pcsrcE       (pcsrcE),
    .memaccessM   (memaccessM),
    .dmem_ready   (dmem_ready),
    .cnt_clr      (cnt_clr),
    .stallF       (stallF),
    .stallD       (stallD),
    .stallE       (stallE),
    .stallM       (stallM),
    .flushD       (flushD),
    .flushE       (flushE),
    .flushW       (flushW),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1D = 5'd0; rs2D = 5'd0; rdE = 5'd0;
    memreadE = 1'b0; pcsrcE = 1'b0; memaccessM = 1'b0;
    dmem_ready = 1'b1; cnt_clr = 1'b0;
  endtask

  task automatic set_loaduse();
    idle();
    memreadE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
  endtask

  task automatic clr_cnts();
    idle();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_loaduse();
    tick();
    vecs++;
    if (ctrl !== C_IDLE) begin
      $display("FAIL reset_ctrl: got %b want %b", ctrl, C_IDLE); errs++;
    end
    vecs++;
    if (stall_cycles !== 4'd0 || flush_events !== 4'd0) begin
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cycles, flush_events); errs++;
    end
    vecs++;
    if (dut.state !== ST_RUN) begin
      $display("FAIL reset_state: got %0d want %0d", dut.state, ST_RUN); errs++;
    end
    idle();
    #2 rst_n = 1'b1;
    tick();
    vecs++;
    if (ctrl !== C_IDLE) begin
      $display("FAIL post_reset_ctrl: got %b want %b", ctrl, C_IDLE); errs++;
    end
  endtask

  task automatic test_load_use();
    clr_cnts();
    set_loaduse();
    #1;
    vecs++;
    if (ctrl !== C_LU) begin
      $display("FAIL lu_ctrl: got %b want %b", ctrl, C_LU); errs++;
    end
    vecs++;
    if (stall_cycles !== 4'd0) begin
      $display("FAIL lu_cnt_before: got %0d want 0", stall_cycles); errs++;
    end
    tick();
    idle();
    #1;
    vecs++;
    if (stall_cycles !== 4'd1 || ctrl !== C_IDLE) begin
      $display("FAIL lu_cnt_after: got cnt=%0d ctrl=%b want cnt=1 ctrl=%b",
               stall_cycles, ctrl, C_IDLE); errs++;
    end
  endtask

  task automatic test_no_dependency();
    idle();
    memreadE = 1'b1; rdE = 5'd0; rs1D = 5'd0; rs2D = 5'd0;
    #1;
    vecs++;
    if (ctrl !== C_IDLE) begin
      $display("FAIL x0_dest: got %b want %b", ctrl, C_IDLE); errs++;
    end
    rdE = 5'd7; rs1D = 5'd3; rs2D = 5'd4;
    #1;
    vecs++;
    if (ctrl !== C_IDLE) begin
      $display("FAIL no_dep: got %b want %b", ctrl, C_IDLE); errs++;
    end
    rs2D = 5'd7;
    #1;
    vecs++;
    if (ctrl !== C_LU) begin
      $display("FAIL rs2_dep: got %b want %b", ctrl, C_LU); errs++;
    end
    memreadE = 1'b0;
    #1;
    vecs++;
    if (ctrl !== C_IDLE) begin
      $display("FAIL not_load: got %b want %b", ctrl, C_IDLE); errs++;
    end
    tick();
  endtask

  task automatic test_branch_vs_loaduse();
    clr_cnts();
    pcsrcE = 1'b1; memreadE = 1'b1; rdE = 5'd9; rs2D = 5'd9; rs1D = 5'd1;
    #1;
    vecs++;
    if (ctrl !== C_BR) begin
      $display("FAIL br_lu_ctrl: got %b want %b", ctrl, C_BR); errs++;
    end
    tick();
    idle();
    #1;
    vecs++;
    if (flush_events !== 4'd1 || stall_cycles !== 4'd0) begin
      $display("FAIL br_lu_cnt: got flush=%0d stall=%0d want flush=1 stall=0",
               flush_events, stall_cycles); errs++;
    end
  endtask

  task automatic test_mem_wait();
    clr_cnts();
    memaccessM = 1'b1; dmem_ready = 1'b0; pcsrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if (ctrl !== C_FRZ) begin
        $display("FAIL mw_freeze%0d: got %b want %b", i, ctrl, C_FRZ); errs++;
      end
      tick();
      vecs++;
      if (dut.state !== ST_MEM_WAIT) begin
        $display("FAIL mw_state%0d: got %0d want %0d", i, dut.state, ST_MEM_WAIT); errs++;
      end
    end
    dmem_ready = 1'b1;
    #1;
    vecs++;
    if (ctrl !== C_BR) begin
      $display("FAIL mw_complete: got %b want %b", ctrl, C_BR); errs++;
    end
    tick();
    idle();
    #1;
    vecs++;
    if (dut.state !== ST_RUN || stall_cycles !== 4'd3 || flush_events !== 4'd1) begin
      $display("FAIL mw_end: got state=%0d stall=%0d flush=%0d want 0/3/1",
               dut.state, stall_cycles, flush_events); errs++;
    end
  endtask

  task automatic test_back_to_back();
    idle();
    memaccessM = 1'b1; dmem_ready = 1'b0;
    memreadE = 1'b1; rdE = 5'd12; rs1D = 5'd12;
    #1;
    vecs++;
    if (ctrl !== C_FRZ) begin
      $display("FAIL b2b_freeze: got %b want %b", ctrl, C_FRZ); errs++;
    end
    tick();
    dmem_ready = 1'b1;
    #1;
    vecs++;
    if (ctrl !== C_LU) begin
      $display("FAIL b2b_complete_lu: got %b want %b", ctrl, C_LU); errs++;
    end
    tick();
    // Freeze 3, break, freeze 4: the break must restart the timeout count.
    idle();
    memaccessM = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      dmem_ready = (k == 4) ? 1'b1 : 1'b0;
      #1;
      vecs++;
      if (ctrl !== ((k == 4) ? C_IDLE : (k == 8) ? C_FRZ_TO : C_FRZ)) begin
        $display("FAIL b2b_restart%0d: got %b", k, ctrl); errs++;
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_timeout_and_reset();
    clr_cnts();
    memaccessM = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      #1;
      vecs++;
      if (ctrl !== ((k == 4 || k == 8) ? C_FRZ_TO : C_FRZ)) begin
        $display("FAIL to_cycle%0d: got %b want %b", k, ctrl,
                 (k == 4 || k == 8) ? C_FRZ_TO : C_FRZ); errs++;
      end
      tick();
    end
    vecs++;
    if (stall_cycles !== 4'd9 || dut.state !== ST_MEM_WAIT) begin
      $display("FAIL to_progress: got stall=%0d state=%0d want 9/%0d",
               stall_cycles, dut.state, ST_MEM_WAIT); errs++;
    end
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if (ctrl !== C_IDLE || dut.state !== ST_RUN ||
        stall_cycles !== 4'd0 || flush_events !== 4'd0) begin
      $display("FAIL to_async_reset: got ctrl=%b state=%0d stall=%0d flush=%0d want 0/0/0/0",
               ctrl, dut.state, stall_cycles, flush_events); errs++;
    end
    idle();
    #1 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    clr_cnts();
    set_loaduse();
    for (int i = 0; i < 15; i++) tick();
    vecs++;
    if (stall_cycles !== 4'd15) begin
      $display("FAIL sat_reach: got %0d want 15", stall_cycles); errs++;
    end
    for (int i = 0; i < 5; i++) tick();
    vecs++;
    if (stall_cycles !== 4'd15) begin
      $display("FAIL sat_hold: got %0d want 15", stall_cycles); errs++;
    end
    cnt_clr = 1'b1;
    #1;
    vecs++;
    if (ctrl !== C_LU) begin
      $display("FAIL sat_clr_ctrl: got %b want %b", ctrl, C_LU); errs++;
    end
    tick();
    idle();
    #1;
    vecs++;
    if (stall_cycles !== 4'd0) begin
      $display("FAIL sat_clr_wins: got %0d want 0", stall_cycles); errs++;
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_dependency();
    test_branch_vs_loaduse();
    test_mem_wait();
    test_back_to_back();
    test_timeout_and_reset();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_pipe_stall_ctrl

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside the forwarding unit in the execute-stage control path.
- Generates stall and flush enables for the F/D/E/M/W pipeline registers. It covers three cases the forwarding unit cannot resolve: load-use hazards, taken branch/jump redirects, and multi-cycle data-memory waits.
- Keeps saturating performance counters for stall cycles and flush events, and flags data-memory timeouts.

Parameters:
- TIMEOUT, 16: consecutive frozen cycles of one memory access before mem_timeout pulses; legal range 2..255.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  core clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- rs1D  in  5  rs1 of the instruction in Decode
- rs2D  in  5  rs2 of the instruction in Decode
- rdE  in  5  destination register of the instruction in Execute
- memreadE  in  1  instruction in Execute is a load
- pcsrcE  in  1  taken branch/jump resolved in Execute
- memaccessM  in  1  load or store in Memory stage
- dmem_ready  in  1  data memory completes the access this cycle
- cnt_clr  in  1  synchronous clear of both counters
- stallF, stallD, stallE, stallM  out  1 each  hold the corresponding pipeline register
- flushD, flushE, flushW  out  1 each  clear the corresponding pipeline register to a bubble
- mem_timeout  out  1  one-cycle pulse on timeout
- stall_cycles  out  CNT_W  cycles with stallF=1
- flush_events  out  CNT_W  cycles with a branch flush applied

Behaviour:
- State register: RUN, MEM_WAIT. Reset value is RUN. wait_cnt is 8 bits, reset 0.
- While rst_n=0, all control outputs and mem_timeout are 0, both counters are 0, and state is RUN. Reset is asynchronous, including mid-MEM_WAIT.
- Control outputs are combinational from state and inputs, so they take effect in the same cycle (zero latency).
- Definitions:
  - freeze = memaccessM & !dmem_ready
  - loaduse = memreadE & (rdE!=0) & ((rdE==rs1D) | (rdE==rs2D))
- Priority each cycle, in either state:
  1. freeze: stallF=stallD=stallE=stallM=1 and flushW=1. All other outputs are 0. pcsrcE and loaduse are ignored because the stages are held and re-evaluate later.
  2. else pcsrcE: flushD=flushE=1 and no stalls. Branch beats load-use because the dependent instruction is squashed.
  3. else loaduse: stallF=stallD=1 and flushE=1.
  4. else: all outputs 0.
- RUN -> MEM_WAIT when freeze.
- MEM_WAIT -> RUN when !freeze. The completing cycle (dmem_ready=1) is decoded by priority 2-4 in that same cycle.
- wait_cnt:
  - On a freeze cycle: if wait_cnt==TIMEOUT-1, mem_timeout=1 that cycle and wait_cnt returns to 0. Otherwise wait_cnt increments.
  - On any non-freeze cycle: wait_cnt returns to 0.
  - mem_timeout does not release the freeze. The state stays MEM_WAIT until dmem_ready.
- Counters are registered and update on the clock edge after the event. They saturate at 2^CNT_W-1 with no wrap.
  - stall_cycles increments on every cycle with stallF=1, including freeze cycles.
  - flush_events increments on every priority-2 cycle.
  - cnt_clr has priority over increment: the next value is 0, and any event in that same cycle is lost.
- rs1D/rs2D fields of instructions that don't use them are the decoder's responsibility. Spurious stalls from such fields are tolerated.

Decomposition:
- Shared package: state encoding (ST_RUN, ST_MEM_WAIT) and the register-index width constant (5). The core's forwarding and decode logic share these.
- One sub-module: sat_counter (params W; ports clk, rst_n, clr, inc, q). Instantiated twice.

Test Plan:
- Load-use: memreadE=1, rdE=5, rs1D=5, no other events for one cycle -> stallF=stallD=flushE=1 that cycle, all else 0. stall_cycles goes 0->1 on the next edge.
- x0 and no dependency: memreadE=1 with rdE=0, rs1D=0 -> all outputs 0. Repeat with rdE=7, rs1D=3, rs2D=4 -> all outputs 0.
- Branch plus load-use in the same cycle: pcsrcE=1, memreadE=1, rdE=rs2D=9 -> flushD=flushE=1, stallF=0. flush_events +1, stall_cycles unchanged.
- Memory wait: memaccessM=1, dmem_ready=0 for 3 cycles, then 1, plus pcsrcE=1 throughout -> 3 freeze cycles (4 stalls + flushW). The 4th cycle gives flushD=flushE=1 and state RUN. stall_cycles +3.
- Timeout with TIMEOUT=4: dmem_ready held 0 for 9 cycles -> mem_timeout pulses on frozen cycles 4 and 8 only, and the freeze persists throughout. Assert rst_n=0 mid-wait -> outputs 0 immediately, state RUN, counters 0.
- Saturation with CNT_W=4: 20 load-use cycles -> stall_cycles holds 15. cnt_clr together with a stall cycle -> counter reads 0 next cycle.
